// File: rtl/seq_mul_param.sv
// Parametrised shift-and-add multiplier with valid/ready handshakes on both sides.
// Define SEQ_MUL_SIGNED_EN to honour signed_op_i (two's-complement via magnitude and final negate).
module seq_mul_param #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     mul_a_i,
    input  logic [WIDTH-1:0]     mul_b_i,
    input  logic                 signed_op_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 busy_o
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [PW-1:0]      b_q, b_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               neg_in;
    logic [PW-1:0]      acc_next;
    logic               last_iter;

`ifdef SEQ_MUL_SIGNED_EN
    // Magnitude of the most negative value wraps to itself, which is correct read as unsigned.
    always_comb begin
        mag_a  = (signed_op_i && mul_a_i[WIDTH-1]) ? -mul_a_i : mul_a_i;
        mag_b  = (signed_op_i && mul_b_i[WIDTH-1]) ? -mul_b_i : mul_b_i;
        neg_in = signed_op_i && (mul_a_i[WIDTH-1] ^ mul_b_i[WIDTH-1]);
    end
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op_i;
    assign mag_a  = mul_a_i;
    assign mag_b  = mul_b_i;
    assign neg_in = 1'b0;
`endif

    assign acc_next  = a_q[0] ? (acc_q + b_q) : acc_q;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        prod_d      = prod_q;
        out_valid_d = out_valid_q;

        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d     = mag_a;
                    b_d     = {{WIDTH{1'b0}}, mag_b};
                    acc_d   = '0;
                    cnt_d   = '0;
                    neg_d   = neg_in;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                acc_d = acc_next;
                a_d   = a_q >> 1;
                b_d   = b_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
`ifdef SEQ_MUL_SIGNED_EN
                    prod_d = neg_q ? -acc_next : acc_next;
`else
                    prod_d = acc_next;
`endif
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d     = StIdle;
                a_d         = '0;
                b_d         = '0;
                acc_d       = '0;
                cnt_d       = '0;
                neg_d       = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign out_valid_o = out_valid_q;
    assign product_o   = prod_q;

endmodule

// File: tb/tb_seq_mul_param.sv
// Self-checking bench for seq_mul_param (WIDTH=8): directed table, corner sequences, random ops.
module tb_seq_mul_param;
    localparam int unsigned W  = 8;
    localparam int unsigned PW = 2 * W;
`ifdef SEQ_MUL_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic          signed_op;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] product;
    logic          busy;

    int            checks = 0;
    int            failures = 0;
    logic [PW-1:0] prev_prod;

    seq_mul_param #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .mul_a_i     (mul_a),
        .mul_b_i     (mul_b),
        .signed_op_i (signed_op),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .product_o   (product),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          s;
        int            hold;
        logic [PW-1:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer multiply of the operands' numeric values, truncated to 2*W bits.
    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
        longint sa;
        longint sb;
        sa = longint'(a);
        sb = longint'(b);
        if (SIGNED_EN && s) begin
            if (a[W-1]) sa = sa - (longint'(1) << W);
            if (b[W-1]) sb = sb - (longint'(1) << W);
        end
        return PW'(sa * sb);
    endfunction

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input int hold, input logic [PW-1:0] exp);
        int  n;
        int  lat;
        bit  seen;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, " idle before accept"}, 64'(in_ready), 64'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        mul_a     = a;
        mul_b     = b;
        signed_op = s;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        chk({name, " busy after accept"}, 64'(busy), 64'd1);
        chk({name, " in_ready low in calc"}, 64'(in_ready), 64'd0);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < int'(W) + 4) begin
            // Garbage on the inputs while busy must be ignored.
            in_valid  = 1'($urandom_range(0, 1));
            mul_a     = W'($urandom);
            mul_b     = W'($urandom);
            signed_op = 1'($urandom_range(0, 1));
            if (lat == int'(W) / 2) chk({name, " product held in calc"}, 64'(product),
                                        64'(prev_prod));
            @(posedge clk); #1;
            lat++;
            seen = (out_valid === 1'b1);
        end
        chk({name, " latency"}, 64'(lat), 64'(W));
        chk({name, " product"}, 64'(product), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, " out_valid held"}, 64'(out_valid), 64'd1);
            chk({name, " in_ready low in done"}, 64'(in_ready), 64'd0);
            chk({name, " product stable"}, 64'(product), 64'(exp));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({name, " out_valid drop"}, 64'(out_valid), 64'd0);
        chk({name, " in_ready back"}, 64'(in_ready), 64'd1);
        chk({name, " product after"}, 64'(product), 64'(exp));
        out_ready = 1'b0;
        prev_prod = exp;
    endtask

    initial begin
        int spurious;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        logic          rs;

        vecs[0] = '{8'd13,  8'd11,  1'b0, 0, 16'h008F};
        vecs[1] = '{8'd255, 8'd255, 1'b0, 0, 16'hFE01};
        vecs[2] = '{8'd0,   8'hA5,  1'b0, 0, 16'h0000};
        vecs[3] = '{8'd200, 8'd3,   1'b0, 5, 16'h0258};
        vecs[4] = '{8'hFD,  8'h05,  1'b1, 0, SIGNED_EN ? 16'hFFF1 : 16'h04F1};
        vecs[5] = '{8'h80,  8'h80,  1'b1, 1, 16'h4000};
        vecs[6] = '{8'h80,  8'h7F,  1'b1, 0, SIGNED_EN ? 16'hC080 : 16'h3F80};
        vecs[7] = '{8'h07,  8'hFF,  1'b1, 2, SIGNED_EN ? 16'hFFF9 : 16'h06F9};
        vecs[8] = '{8'hFD,  8'h05,  1'b0, 0, 16'h04F1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        signed_op = 1'b0;
        out_ready = 1'b0;
        prev_prod = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset product", 64'(product), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].hold,
                   vecs[i].exp);
        end

        // Reset in the middle of CALC discards the operation.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        mul_a     = 8'd9;
        mul_b     = 8'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("midreset in_ready", 64'(in_ready), 64'd1);
        chk("midreset out_valid", 64'(out_valid), 64'd0);
        chk("midreset product", 64'(product), 64'd0);
        chk("midreset busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        spurious = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) spurious++;
        end
        chk("midreset no out_valid pulse", 64'(spurious), 64'd0);
        out_ready = 1'b0;
        prev_prod = '0;
        run_op("after reset 6x7", 8'd6, 8'd7, 1'b0, 0, 16'h002A);

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), ra, rb, rs, int'($urandom_range(0, 2)),
                   ref_mul(ra, rb, rs));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_mul_param.md
# seq_mul_param

Parametrised sequential shift-and-add multiplier: the next generation of the 8-bit serial multiplier. It generalises operand width, replaces the single-pulse enable/done pair with valid/ready handshakes on both sides, and, when compiled in, supports two's-complement operands. It sits in the datapath as a low-area arithmetic unit behind a producer that can stall and ahead of a consumer that can apply backpressure.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32
- CNT_W, $clog2(WIDTH+1), iteration-counter width; derived, not overridden
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands; high only in IDLE
- mul_a  input  WIDTH  multiplier operand, sampled on accept
- mul_b  input  WIDTH  multiplicand operand, sampled on accept
- signed_op  input  1  1 = treat operands as two's complement; sampled on accept
- out_valid  output  1  product valid; registered
- out_ready  input  1  consumer takes product
- product  output  2*WIDTH  result; registered, holds until next result is loaded
- busy  output  1  state != IDLE

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, CALC, DONE; 2-bit encoding; unused encoding goes to IDLE with working registers cleared.
- IDLE: in_ready=1. Accept = in_valid && in_ready. On accept: load a_reg (WIDTH bits), b_reg (2*WIDTH bits, zero-extended), clear acc and counter, latch neg_flag, go to CALC.
- Signed path (macro on, signed_op=1): a_reg/b_reg load operand magnitudes; neg_flag = mul_a[MSB] ^ mul_b[MSB]. The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits unsigned in WIDTH bits.
- CALC, one iteration per cycle: if a_reg[0], acc <= acc + b_reg (2*WIDTH-bit add, no overflow possible); a_reg >>= 1; b_reg <<= 1; counter++.
- The last iteration is the one where counter == WIDTH-1. On that edge, product <= neg_flag ? -(acc_next) : acc_next, where acc_next is the accumulator value after the final add; out_valid <= 1; state <= DONE.
- DONE: out_valid=1 and product stable. On out_ready: out_valid <= 0, state <= IDLE. in_ready stays 0 throughout DONE.
- No early termination. Every operation takes exactly WIDTH CALC cycles.
- Operand inputs are ignored outside the accept cycle. signed_op is ignored when unsigned results are required.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, all working registers=0.
- Accept at edge T. CALC occupies cycles T..T+WIDTH-1. out_valid rises after edge T+WIDTH, so latency is WIDTH clocks from the accept edge to out_valid.
- Back-to-back operation: with out_ready tied high, out_valid lasts one cycle and in_ready returns one cycle later. Minimum initiation interval is WIDTH+2 cycles.
- out_ready asserted before out_valid has no effect.
- in_valid held during CALC or DONE is not accepted. The producer must hold its operands until in_ready is high.
- Reset asserted mid-CALC or mid-DONE returns the block to reset values immediately. The partial result is discarded and no out_valid is produced.
- product keeps its last value in IDLE and CALC and changes only on the final CALC edge.

## Configuration
- SEQ_MUL_SIGNED_EN defined: signed_op is honoured and implements the magnitude/negate path above.
- SEQ_MUL_SIGNED_EN undefined: signed_op is ignored and all operands are treated as unsigned. The magnitude logic and final negation are removed, and neg_flag is tied to 0.
- Cycle timing is identical in both builds.

## Test plan
All scenarios use WIDTH=8.
- Reset: after reset, expect in_ready=1, out_valid=0, product=0x0000, busy=0.
- Unsigned, out_ready=1: 13×11 → product=0x008F (143), out_valid exactly 8 clocks after accept. 255×255 → 0xFE01. 0×0xA5 → 0x0000.
- Backpressure: 200×3 with out_ready=0 for 5 cycles → out_valid and product=0x0258 held stable and in_ready=0 throughout. out_ready=1 → next cycle out_valid=0 and in_ready=1.
- Signed, macro on: -3×5 (0xFD, 0x05) → 0xFFF1. -128×-128 → 0x4000. -128×127 → 0xC080. 7×-1 → 0xFFF9.
- Macro off, signed_op=1: 0xFD×0x05 → 0x04F1 (unsigned 1265).
- Reset after 4 CALC cycles: all outputs return to reset values and no out_valid pulse follows. A new 6×7 operation then yields 0x002A.
